// File: rtl/pll_reconf_pkg.sv
// Shared definitions for the HDMI pixel-clock PLL reconfiguration sequencer.
// Optional read-back verification is compiled in with PLL_RECONF_VERIFY_EN.
package pll_reconf_pkg;

  localparam int MODE_W    = 2;
  localparam int NUM_MODES = 1 << MODE_W;
  localparam int ROM_DEPTH = 8;

  localparam int DEF_LOCK_TIMEOUT = 2_700_000;
  localparam int DEF_LOCK_STABLE  = 8;

  localparam logic [1:0] MD_NOP   = 2'b00;
  localparam logic [1:0] MD_WRITE = 2'b01;
  localparam logic [1:0] MD_READ  = 2'b10;
  localparam logic [1:0] MD_ADDR  = 2'b11;

  typedef enum logic [3:0] {
    ST_RST,
    ST_ADDR,
    ST_WR,
`ifdef PLL_RECONF_VERIFY_EN
    ST_VFY,
`endif
    ST_REL,
    ST_LOCK,
    ST_DONE,
    ST_FAIL,
    ST_IDLE
  } state_t;

endpackage

// File: rtl/pll_reconf_rom.sv
// Divider register sets for the four pixel clocks, indexed by (mode, byte).
// Mode 0: 74.25 MHz, 1: 27 MHz, 2: 25.2 MHz, 3: 148.5 MHz.
module pll_reconf_rom
  import pll_reconf_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [MODE_W-1:0] i_mode,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [7:0]        o_data
);

  localparam logic [7:0] DIV_TBL [NUM_MODES][ROM_DEPTH] = '{
    '{8'h01, 8'h2C, 8'h03, 8'h10, 8'h04, 8'h80, 8'h21, 8'h07},
    '{8'h01, 8'h14, 8'h05, 8'h08, 8'h02, 8'h40, 8'h11, 8'h03},
    '{8'h02, 8'h38, 8'h07, 8'h1C, 8'h06, 8'hA0, 8'h31, 8'h0B},
    '{8'h01, 8'h2C, 8'h01, 8'h10, 8'h04, 8'h80, 8'h21, 8'h0F}
  };

  // Bytes beyond the stored table read as zero.
  always_comb begin
    o_data = '0;
    if (32'(i_idx) < ROM_DEPTH) begin
      o_data = DIV_TBL[i_mode][3'(i_idx)];
    end
  end

endmodule

// File: rtl/pll_reconf_ctrl.sv
// MD-port sequencer: reset PLL, program divider set, optionally verify, qualify lock.
// Read-back verification is compiled in when PLL_RECONF_VERIFY_EN is defined.
module pll_reconf_ctrl
  import pll_reconf_pkg::*;
#(
  parameter int                NREGS        = 8,
  parameter logic [7:0]        START_ADDR   = 8'h00,
  parameter int                RST_CYCLES   = 16,
  parameter int                LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int                LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter logic [MODE_W-1:0] DEFAULT_MODE = '0
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              cfg_req,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [MODE_W-1:0] cur_mode,
  output logic              locked,
  output logic              pll_reset,
  input  logic              pll_lock,
  output logic [1:0]        mdopc,
  output logic              mdainc,
  output logic [7:0]        mdwdi,
  input  logic [7:0]        mdrdo
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int RC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NREGS - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [7:0]       STB_LAST = 8'(LOCK_STABLE - 1);
  localparam logic [21:0]      TMO_LAST = 22'(LOCK_TIMEOUT - 1);

  state_t              r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [IDX_W-1:0]    r_idx;
  logic                r_ph;
  logic [RC_W-1:0]     r_rcnt;
  logic [7:0]          r_scnt;
  logic [21:0]         r_tcnt;
  logic                r_lock_s1;
  logic                r_lock_s2;

  logic                r_busy;
  logic                r_cfg_done;
  logic                r_cfg_err;
  logic [MODE_W-1:0]   r_cur_mode;
  logic                r_locked;
  logic                r_pll_reset;
  logic [1:0]          r_mdopc;
  logic                r_mdainc;
  logic [7:0]          r_mdwdi;

`ifdef PLL_RECONF_VERIFY_EN
  logic [1:0]          r_vph;
`endif

  logic [IDX_W-1:0]    w_rom_idx;
  logic [7:0]          w_rom_data;

  // WR pre-fetches the next byte so the WRITE data is registered with the command.
  always_comb begin
    w_rom_idx = r_idx;
    if (r_state == ST_WR) begin
      w_rom_idx = r_idx + IDX_W'(1);
    end
  end

  pll_reconf_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .i_mode (r_mode),
    .i_idx  (w_rom_idx),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_lock;
      r_lock_s2 <= r_lock_s1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state     <= ST_RST;
      r_mode      <= DEFAULT_MODE;
      r_idx       <= '0;
      r_ph        <= 1'b0;
      r_rcnt      <= '0;
      r_scnt      <= '0;
      r_tcnt      <= '0;
      r_busy      <= 1'b1;
      r_cfg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cur_mode  <= '0;
      r_locked    <= 1'b0;
      r_pll_reset <= 1'b1;
      r_mdopc     <= MD_NOP;
      r_mdainc    <= 1'b0;
      r_mdwdi     <= '0;
`ifdef PLL_RECONF_VERIFY_EN
      r_vph       <= '0;
`endif
    end else begin
      r_cfg_done <= 1'b0;
      r_locked   <= r_lock_s2 && !r_busy && !(r_state == ST_IDLE && cfg_req);

      unique case (r_state)
        ST_IDLE: begin
          if (cfg_req) begin
            r_mode      <= cfg_mode;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b1;
            r_pll_reset <= 1'b1;
            r_rcnt      <= '0;
            r_state     <= ST_RST;
          end
        end

        ST_RST: begin
          if (r_rcnt == RC_LAST) begin
            r_idx   <= '0;
            r_mdopc <= MD_ADDR;
            r_mdwdi <= START_ADDR;
            r_state <= ST_ADDR;
          end else begin
            r_rcnt <= r_rcnt + RC_W'(1);
          end
        end

        ST_ADDR: begin
          r_mdopc  <= MD_WRITE;
          r_mdainc <= 1'b1;
          r_mdwdi  <= w_rom_data;
          r_ph     <= 1'b0;
          r_state  <= ST_WR;
        end

        ST_WR: begin
          if (!r_ph) begin
            r_mdopc  <= MD_NOP;
            r_mdainc <= 1'b0;
            r_ph     <= 1'b1;
          end else if (r_idx == IDX_LAST) begin
`ifdef PLL_RECONF_VERIFY_EN
            r_idx   <= '0;
            r_vph   <= '0;
            r_mdopc <= MD_ADDR;
            r_mdwdi <= START_ADDR;
            r_state <= ST_VFY;
`else
            r_pll_reset <= 1'b0;
            r_state     <= ST_REL;
`endif
          end else begin
            r_idx    <= r_idx + IDX_W'(1);
            r_mdopc  <= MD_WRITE;
            r_mdainc <= 1'b1;
            r_mdwdi  <= w_rom_data;
            r_ph     <= 1'b0;
          end
        end

`ifdef PLL_RECONF_VERIFY_EN
        // Phases: 0 = ADDR issued, 1 = READ issued, 2 = read data valid on mdrdo.
        ST_VFY: begin
          unique case (r_vph)
            2'd0: begin
              r_mdopc  <= MD_READ;
              r_mdainc <= 1'b1;
              r_vph    <= 2'd1;
            end
            2'd1: begin
              r_mdopc  <= MD_NOP;
              r_mdainc <= 1'b0;
              r_vph    <= 2'd2;
            end
            default: begin
              if (mdrdo != w_rom_data) begin
                r_state <= ST_FAIL;
              end else if (r_idx == IDX_LAST) begin
                r_pll_reset <= 1'b0;
                r_state     <= ST_REL;
              end else begin
                r_idx    <= r_idx + IDX_W'(1);
                r_mdopc  <= MD_READ;
                r_mdainc <= 1'b1;
                r_vph    <= 2'd1;
              end
            end
          endcase
        end
`endif

        ST_REL: begin
          r_tcnt  <= '0;
          r_scnt  <= '0;
          r_state <= ST_LOCK;
        end

        ST_LOCK: begin
          if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + 22'd1;
          end
          if (r_lock_s2 && r_scnt == STB_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_scnt <= r_lock_s2 ? r_scnt + 8'd1 : '0;
            if (r_tcnt >= TMO_LAST) begin
              r_state <= ST_FAIL;
            end
          end
        end

        ST_DONE: begin
          r_cur_mode <= r_mode;
          r_cfg_done <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        ST_FAIL: begin
          r_cfg_err  <= 1'b1;
          r_cfg_done <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_pll_reset <= 1'b1;
          r_busy      <= 1'b1;
          r_rcnt      <= '0;
          r_state     <= ST_RST;
        end
      endcase
    end
  end

  assign cfg_busy  = r_busy;
  assign cfg_done  = r_cfg_done;
  assign cfg_err   = r_cfg_err;
  assign cur_mode  = r_cur_mode;
  assign locked    = r_locked;
  assign pll_reset = r_pll_reset;
  assign mdopc     = r_mdopc;
  assign mdainc    = r_mdainc;
  assign mdwdi     = r_mdwdi;

endmodule

// File: tb/tb_pll_reconf_ctrl.sv
// Directed bench for pll_reconf_ctrl with a small MD register-file and lock model.
// Build with PLL_RECONF_VERIFY_EN to exercise the read-back path.
module tb_pll_reconf_ctrl;

  localparam int T_TMO = 1000;

`ifdef PLL_RECONF_VERIFY_EN
  localparam int VX = 17, EXP_ADDR = 2, EXP_RD = 8;
`else
  localparam int VX = 0, EXP_ADDR = 1, EXP_RD = 0;
`endif

  localparam logic [7:0] EXP_ROM [4][8] = '{
    '{8'h01, 8'h2C, 8'h03, 8'h10, 8'h04, 8'h80, 8'h21, 8'h07},
    '{8'h01, 8'h14, 8'h05, 8'h08, 8'h02, 8'h40, 8'h11, 8'h03},
    '{8'h02, 8'h38, 8'h07, 8'h1C, 8'h06, 8'hA0, 8'h31, 8'h0B},
    '{8'h01, 8'h2C, 8'h01, 8'h10, 8'h04, 8'h80, 8'h21, 8'h0F}
  };

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_req = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic       cfg_busy, cfg_done, cfg_err, locked, pll_reset, mdainc;
  logic [1:0] cur_mode, mdopc;
  logic [7:0] mdwdi;
  logic       pll_lock = 1'b0;
  logic [7:0] mdrdo = 8'h00;

  always #5 clkin = ~clkin;

  pll_reconf_ctrl #(
    .NREGS        (8),
    .START_ADDR   (8'h00),
    .RST_CYCLES   (16),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (T_TMO),
    .DEFAULT_MODE (2'd0)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .cfg_req   (cfg_req),
    .cfg_mode  (cfg_mode),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cur_mode  (cur_mode),
    .locked    (locked),
    .pll_reset (pll_reset),
    .pll_lock  (pll_lock),
    .mdopc     (mdopc),
    .mdainc    (mdainc),
    .mdwdi     (mdwdi),
    .mdrdo     (mdrdo)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // MD register file: ADDR loads the pointer, WRITE stores, READ returns data next cycle.
  logic [7:0] md [256];
  logic [7:0] ptr = 8'h00;
  bit         corrupt = 1'b0;
  always @(posedge clkin) begin
    case (mdopc)
      2'b11: ptr <= mdwdi;
      2'b01: begin
        md[ptr] <= mdwdi;
        if (mdainc) ptr <= ptr + 8'd1;
      end
      2'b10: begin
        mdrdo <= md[ptr] ^ ((corrupt && ptr == 8'd3) ? 8'h5A : 8'h00);
        if (mdainc) ptr <= ptr + 8'd1;
      end
      default: ;
    endcase
  end

  logic [7:0] wq[$];
  int n_addr, n_rd, n_bad, addr_cyc, t0;

  always @(negedge clkin) begin
    if (mdopc == 2'b11) begin
      if (n_addr == 0) addr_cyc = cyc;
      n_addr++;
      if (mdwdi !== 8'h00) n_bad++;
    end
    if (mdopc == 2'b01) begin
      wq.push_back(mdwdi);
      if (!mdainc) n_bad++;
    end
    if (mdopc == 2'b10) begin
      n_rd++;
      if (!mdainc) n_bad++;
    end
    if (mdopc == 2'b00 && mdainc) n_bad++;
  end

  task automatic mon_clear();
    wq.delete();
    n_addr   = 0;
    n_rd     = 0;
    n_bad    = 0;
    addr_cyc = -1;
  endtask

  task automatic req(input logic [1:0] m);
    cfg_mode = m;
    cfg_req  = 1'b1;
    t0       = cyc;
    mon_clear();
    @(negedge clkin);
    cfg_req = 1'b0;
  endtask

  task automatic wait_rel(input string tag);
    int n = 0;
    while (pll_reset && n < 300) begin
      @(negedge clkin);
      n++;
    end
    chk(tag, pll_reset, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!cfg_done && n < budget) begin
      @(negedge clkin);
      n++;
    end
    chk(tag, cfg_done, 1'b1);
  endtask

  task automatic chk_writes(input string tag, input int m);
    chk($sformatf("%s_naddr", tag), n_addr, EXP_ADDR);
    chk($sformatf("%s_nrd", tag), n_rd, EXP_RD);
    chk($sformatf("%s_proto", tag), n_bad, 0);
    chk($sformatf("%s_nwr", tag), wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), wq[i], EXP_ROM[m][i]);
    end
  endtask

  int tl;

  initial begin
    mon_clear();
    repeat (3) @(negedge clkin);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_busy", cfg_busy, 1);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_cur_mode", cur_mode, 0);
    chk("rst_locked", locked, 0);
    chk("rst_mdopc", mdopc, 0);
    chk("rst_mdainc", mdainc, 0);
    chk("rst_mdwdi", mdwdi, 0);

    // Automatic sequence after reset, lock 500 cycles after release.
    reset = 1'b0;
    mon_clear();
    wait_rel("t1_rel");
    repeat (500) @(negedge clkin);
    pll_lock = 1'b1;
    tl = cyc;
    wait_done("t1_done", 100);
    chk("t1_lock_lat", cyc - tl, 11);
    chk("t1_err", cfg_err, 0);
    chk("t1_cur_mode", cur_mode, 0);
    chk("t1_locked_at_done", locked, 0);
    @(negedge clkin);
    chk("t1_locked", locked, 1);
    chk("t1_done_pulse", cfg_done, 0);
    chk_writes("t1", 0);

    // Request mode 2 from IDLE.
    pll_lock = 1'b0;
    req(2'd2);
    chk("t2_busy", cfg_busy, 1);
    chk("t2_pll_reset", pll_reset, 1);
    chk("t2_locked", locked, 0);
    wait_rel("t2_rel");
    chk("t2_rel_cyc", cyc - t0, 34 + VX);
    chk("t2_addr_cyc", addr_cyc - t0, 17);
    repeat (20) @(negedge clkin);
    pll_lock = 1'b1;
    wait_done("t2_done", 100);
    chk("t2_cur_mode", cur_mode, 2);
    chk("t2_err", cfg_err, 0);
    chk_writes("t2", 2);

    // Lock drop while idle only clears locked.
    repeat (2) @(negedge clkin);
    chk("t3_locked_hi", locked, 1);
    pll_lock = 1'b0;
    repeat (4) @(negedge clkin);
    chk("t3_locked_drop", locked, 0);
    chk("t3_busy", cfg_busy, 0);
    chk("t3_cur_mode", cur_mode, 2);

    // Lock never arrives: timeout failure, cur_mode kept.
    req(2'd1);
    wait_done("t3_to_done", 1200);
    chk("t3_to_cyc", cyc - t0, 1036 + VX);
    chk("t3_to_err", cfg_err, 1);
    chk("t3_to_cur_mode", cur_mode, 2);
    @(negedge clkin);
    chk("t3_to_pulse", cfg_done, 0);
    chk("t3_to_sticky", cfg_err, 1);
    chk("t3_to_idle_busy", cfg_busy, 0);

    // Next request clears the error.
    req(2'd3);
    chk("t3c_err_clr", cfg_err, 0);
    wait_rel("t3c_rel");
    repeat (20) @(negedge clkin);
    pll_lock = 1'b1;
    wait_done("t3c_done", 100);
    chk("t3c_err", cfg_err, 0);
    chk("t3c_cur_mode", cur_mode, 3);
    chk_writes("t3c", 3);

    // Lock glitch restarts the stable count.
    pll_lock = 1'b0;
    req(2'd1);
    wait_rel("t4_rel");
    repeat (20) @(negedge clkin);
    pll_lock = 1'b1;
    tl = cyc;
    repeat (4) @(negedge clkin);
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    wait_done("t4_done", 100);
    chk("t4_lock_lat", cyc - tl, 16);
    chk("t4_cur_mode", cur_mode, 1);

    // Request during the write phase is ignored.
    pll_lock = 1'b0;
    req(2'd2);
    repeat (18) @(negedge clkin);
    cfg_mode = 2'd1;
    cfg_req  = 1'b1;
    @(negedge clkin);
    cfg_req  = 1'b0;
    wait_rel("t5_rel");
    repeat (20) @(negedge clkin);
    pll_lock = 1'b1;
    wait_done("t5_done", 100);
    chk("t5_cur_mode", cur_mode, 2);
    chk_writes("t5", 2);
    mon_clear();
    repeat (60) @(negedge clkin);
    chk("t5_no_second", n_addr, 0);
    chk("t5_idle_busy", cfg_busy, 0);

    // Reset during the write phase restarts with the default mode.
    pll_lock = 1'b0;
    req(2'd3);
    repeat (21) @(negedge clkin);
    reset = 1'b1;
    @(negedge clkin);
    chk("t6_pll_reset", pll_reset, 1);
    chk("t6_busy", cfg_busy, 1);
    chk("t6_mdopc", mdopc, 0);
    @(negedge clkin);
    reset = 1'b0;
    mon_clear();
    wait_rel("t6_rel");
    repeat (20) @(negedge clkin);
    pll_lock = 1'b1;
    wait_done("t6_done", 100);
    chk("t6_cur_mode", cur_mode, 0);
    chk("t6_err", cfg_err, 0);
    chk_writes("t6", 0);

`ifdef PLL_RECONF_VERIFY_EN
    // Corrupted read-back of byte 3 fails with the PLL held in reset.
    pll_lock = 1'b0;
    corrupt  = 1'b1;
    req(2'd1);
    wait_done("t7_done", 200);
    chk("t7_cyc", cyc - t0, 44);
    chk("t7_err", cfg_err, 1);
    chk("t7_pll_reset", pll_reset, 1);
    chk("t7_cur_mode", cur_mode, 0);
    chk("t7_nrd", n_rd, 4);
    corrupt = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pll_reconf_ctrl.md
# pll_reconf_ctrl

Sequencer for the HDMI pixel-clock PLL's dynamic reconfiguration (MD) port. It programs one of four stored divider sets into the PLL register file, holds the PLL in reset during programming, and optionally reads the registers back to check them. It then releases reset and qualifies lock. It sits between the video-mode logic and the PLL wrapper, runs on the 27 MHz crystal clock, and that clock also drives the PLL `mdclk`.

## Interface
- `NREGS`, 8: MD register bytes per mode.
- `START_ADDR`, 8'h00: first MD register address written.
- `RST_CYCLES`, 16: cycles `pll_reset` is held before programming.
- `LOCK_STABLE`, 8: consecutive synchronized-lock cycles required.
- `LOCK_TIMEOUT`, 2_700_000: cycles allowed for lock after release (100 ms).
- `DEFAULT_MODE`, 2'd0: mode programmed automatically after reset.
- `clkin  in  1`: 27 MHz clock; also wired to the PLL `mdclk` at top level.
- `reset  in  1`: synchronous, active-high.
- `cfg_req  in  1`: request reconfiguration; sampled only in IDLE.
- `cfg_mode  in  2`: mode index, captured with `cfg_req`.
- `cfg_busy  out  1`: sequence in progress.
- `cfg_done  out  1`: one-cycle pulse at the end of a sequence (success or failure).
- `cfg_err  out  1`: last sequence failed; sticky until the next accepted request.
- `cur_mode  out  2`: last successfully programmed mode.
- `locked  out  1`: synchronized lock AND not busy.
- `pll_reset  out  1`: to PLL `reset`.
- `pll_lock  in  1`: from PLL `lock`; asynchronous.
- `mdopc  out  2`, `mdainc  out  1`, `mdwdi  out  8`: MD command, auto-increment and write data.
- `mdrdo  in  8`: MD read data.

## Operation
- MD opcodes: NOP=2'b00, WRITE=2'b01, READ=2'b10, ADDR=2'b11. `mdopc` is NOP and `mdainc` is 0 whenever the controller is not issuing a command.
- States and transitions:
  - RST: `pll_reset`=1 for `RST_CYCLES` → ADDR.
  - ADDR: one cycle, `mdopc`=ADDR, `mdwdi`=`START_ADDR` → WR.
  - WR: per byte i, one WRITE cycle (`mdwdi`=rom[mode][i], `mdainc`=1) then one NOP cycle. After byte `NREGS-1` → VFY if compiled in, else REL.
  - VFY: see Configuration.
  - REL: `pll_reset`=0 → LOCK.
  - LOCK: counts consecutive synchronized lock-high cycles. Reaching `LOCK_STABLE` → DONE. A lock-low cycle clears the count. Timeout counter reaching `LOCK_TIMEOUT` → FAIL.
  - DONE: set `cur_mode`=mode, `cfg_done` pulse → IDLE.
  - FAIL: set `cfg_err`, `cfg_done` pulse; `cur_mode` unchanged → IDLE.
- `pll_lock` passes through a 2-flop synchronizer before any use.
- `cfg_req` during busy is ignored; requests are not queued. A request for the already-current mode still runs the full sequence.
- A lock drop while IDLE deasserts `locked` only. There is no automatic retry.
- Timeout counter is 22 bits and saturates; it is cleared on entering LOCK.

## Timing
- Reset values: `pll_reset`=1, `cfg_busy`=1, `cfg_done`=0, `cfg_err`=0, `cur_mode`=0, `locked`=0, `mdopc`=NOP, `mdainc`=0, `mdwdi`=0. State=RST with mode=`DEFAULT_MODE`, so an automatic sequence follows reset.
- `reset` asserted mid-sequence aborts the sequence and restarts at RST with `DEFAULT_MODE`. The partial MD write has no further effect because the PLL stays in reset.
- `cfg_req` high in IDLE at cycle 0 → `cfg_busy`=1 and `pll_reset`=1 at cycle 1.
- First ADDR command at cycle `RST_CYCLES`+1. Write phase lasts 2·`NREGS` cycles.
- `locked` rises 1 cycle after `cfg_done`.
- Lock latency seen by the controller is 2 cycles (synchronizer) plus `LOCK_STABLE`.

## Configuration
- `PLL_RECONF_VERIFY_EN` defined:
  - VFY issues ADDR=`START_ADDR`, then for each byte one READ cycle (`mdainc`=1).
  - `mdrdo` is sampled on the following cycle and compared with the ROM byte.
  - Any mismatch → FAIL, and `pll_reset` stays 1.
  - Adds 1+2·`NREGS` cycles.
- Not defined: the VFY state and compare logic are absent, `mdrdo` is unused, and WR goes directly to REL.

## Structure
- Package `pll_reconf_pkg` holds:
  - MD opcode constants;
  - state enum;
  - mode width (2);
  - default `LOCK_TIMEOUT` and `LOCK_STABLE` values.
- Sub-module `pll_reconf_rom`: combinational table (mode, index) → byte. Holds the 74.25, 27, 25.2 and 148.5 MHz divider sets.

## Test plan
- Reset released with lock model asserting 500 cycles after `pll_reset` falls → exactly one ADDR, then 8 WRITEs of rom[0], then `cfg_done` with `cfg_err`=0, `cur_mode`=0, `locked`=1.
- `cfg_req` with `cfg_mode`=2 while IDLE → `cfg_busy` next cycle, `pll_reset` high for 16 cycles, write data equals rom[2], `cur_mode`=2 on done.
- Lock model never asserts → `cfg_done` with `cfg_err`=1 after 2_700_000 lock cycles, `cur_mode` unchanged. The next request clears `cfg_err`.
- Lock model glitches low on its 5th stable cycle → stable count restarts, and done occurs only after 8 uninterrupted cycles.
- `cfg_req` pulsed during WR → ignored, no second sequence. `reset` asserted during WR → restart at RST with mode 0.
- With `PLL_RECONF_VERIFY_EN` and `mdrdo` corrupted on byte 3 → FAIL, `pll_reset` stays 1, `cfg_err`=1.
